// File: rtl/compare_seq.sv
// -----------------------------------------------------------------------------
// compare_seq
//   Sequential magnitude comparator. Two WIDTH-bit operands are captured on a
//   start request and scanned one DIGIT-bit digit per cycle, most-significant
//   digit first, stopping at the first digit that differs. Signed compares are
//   turned into unsigned ones by flipping both operand MSBs (offset binary).
//
//   The comparison of each digit is registered before it is acted on. A
//   compare whose first differing digit is k therefore raises done k+2 edges
//   after the start-sampling edge (N+1 edges when the operands are equal).
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        compare request, sampled only while idle
//   signed_mode  1 = two's-complement compare, 0 = unsigned (captured with start)
//   A, B         operands (captured with start)
//   busy         high while a compare is in progress
//   done         one-cycle pulse when a new result is registered
//   AeqB/AgtB/AltB  registered result flags, held until the next done
// -----------------------------------------------------------------------------
module compare_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AeqB,
  output logic             AgtB,
  output logic             AltB
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_param_check
    $error("compare_seq: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;        // captured operands, MSB already offset in signed mode
  logic [WIDTH-1:0]   r_b;
  logic [IDX_W-1:0]   r_idx;      // digit currently being compared, 0 = most significant
  logic               r_pv;       // r_pgt/r_plt/r_plast hold a valid digit result
  logic               r_pgt;
  logic               r_plt;
  logic               r_plast;    // registered digit was the least-significant one
  logic               r_busy;
  logic               r_done;
  logic               r_eq;
  logic               r_gt;
  logic               r_lt;

  logic [WIDTH-1:0]   w_sh_a;
  logic [WIDTH-1:0]   w_sh_b;
  logic [DIGIT-1:0]   w_dig_a;
  logic [DIGIT-1:0]   w_dig_b;

  // Shift the selected digit up to the top so it can be taken with a fixed slice.
  assign w_sh_a  = r_a << (r_idx * DIGIT);
  assign w_sh_b  = r_b << (r_idx * DIGIT);
  assign w_dig_a = w_sh_a[WIDTH-1 -: DIGIT];
  assign w_dig_b = w_sh_b[WIDTH-1 -: DIGIT];

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register, regardless of
  // statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_pv    <= 1'b0;
      r_pgt   <= 1'b0;
      r_plt   <= 1'b0;
      r_plast <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Flipping both MSBs maps two's complement onto offset binary,
            // after which a plain unsigned digit scan gives the signed order.
            r_a     <= {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
            r_b     <= {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
            r_idx   <= '0;
            r_pv    <= 1'b0;
            r_state <= CMP;
            r_busy  <= 1'b1;
          end
        end

        CMP: begin
          if (r_pv && (r_pgt || r_plt)) begin
            // First differing digit decides the result.
            r_eq    <= 1'b0;
            r_gt    <= r_pgt;
            r_lt    <= r_plt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pv    <= 1'b0;
            r_state <= IDLE;
          end else if (r_pv && r_plast) begin
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pv    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_pgt   <= (w_dig_a > w_dig_b);
            r_plt   <= (w_dig_a < w_dig_b);
            r_plast <= (r_idx == LAST_IDX);
            r_pv    <= 1'b1;
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign AeqB = r_eq;
  assign AgtB = r_gt;
  assign AltB = r_lt;

endmodule

// File: tb/tb_compare_seq.sv
// -----------------------------------------------------------------------------
// tb_compare_seq
//   Directed scenarios followed by a randomised sweep for compare_seq
//   (WIDTH=16, DIGIT=4). Expected results come from integer comparison of the
//   operands; expected latency comes from the position of the first nonzero
//   digit of A^B.
// -----------------------------------------------------------------------------
module tb_compare_seq;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int MAX_WAIT = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             AeqB;
  logic             AgtB;
  logic             AltB;

  int n_total = 0;
  int n_fail  = 0;

  // Result flags the DUT should be holding: {eq, gt, lt}.
  logic [2:0] prev_res = 3'b000;

  compare_seq #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (a),
    .B           (b),
    .busy        (busy),
    .done        (done),
    .AeqB        (AeqB),
    .AgtB        (AgtB),
    .AltB        (AltB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: ordering by integer value, latency from the first
  // differing digit counted from the most-significant end.
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] av,
                                           input logic [WIDTH-1:0] bv,
                                           input logic sm);
    int ia, ib;
    ia = sm ? int'($signed(av)) : int'(av);
    ib = sm ? int'($signed(bv)) : int'(bv);
    if (ia == ib) return 3'b100;
    if (ia > ib)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] x;
    x = av ^ bv;
    for (int k = 0; k < N; k++) begin
      if (((x >> (WIDTH - (k + 1) * DIGIT)) & ((1 << DIGIT) - 1)) != 0) return k + 2;
    end
    return N + 1;
  endfunction

  // Drive a start request; call at a falling edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sm);
    a           = av;
    b           = bv;
    signed_mode = sm;
    start       = 1'b1;
  endtask

  // Wait for the compare launched by the previous call to launch() and check
  // latency, busy, result stability while busy, and the final result. With
  // hold=1, start stays high and operands are scrambled while busy. Returns
  // at the falling edge inside the done cycle.
  task automatic finish_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic sm, input bit hold, input string tag);
    logic [2:0] exp_res;
    int         exp_lat;
    int         edges;
    bit         seen;
    exp_res = model_res(av, bv, sm);
    exp_lat = model_lat(av, bv);
    edges   = 0;
    seen    = 1'b0;
    // Start-sampling edge.
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy after start"}, busy, 1'b1);
    while (!seen && edges < MAX_WAIT) begin
      if (!hold) begin
        start = 1'b0;
      end else begin
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        signed_mode = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (done) begin
        seen = 1'b1;
      end else begin
        check({tag, " result held while busy"}, {AeqB, AgtB, AltB}, prev_res);
      end
    end
    start = 1'b0;
    check({tag, " latency"}, edges, exp_lat);
    check({tag, " busy low at done"}, busy, 1'b0);
    check({tag, " result"}, {AeqB, AgtB, AltB}, exp_res);
    prev_res = exp_res;
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] mask;

    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;

    // Reset state, before any clock edge has occurred.
    #2;
    check("reset outputs", {busy, done, AeqB, AgtB, AltB}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle with start low: nothing changes.
    repeat (3) @(negedge clk);
    check("idle no activity", {busy, done, AeqB, AgtB, AltB}, 5'b0);

    // Equal operands run to the last digit.
    launch(16'h1234, 16'h1234, 1'b0);
    finish_op(16'h1234, 16'h1234, 1'b0, 1'b0, "eq_1234");
    @(negedge clk);
    check("done single cycle", done, 1'b0);

    // Early termination on the first digit, unsigned then signed.
    launch(16'hF000, 16'h0FFF, 1'b0);
    finish_op(16'hF000, 16'h0FFF, 1'b0, 1'b0, "F000_u");
    @(negedge clk);
    launch(16'hF000, 16'h0FFF, 1'b1);
    finish_op(16'hF000, 16'h0FFF, 1'b1, 1'b0, "F000_s");
    @(negedge clk);

    // Difference only in the last digit, then back-to-back start in the done cycle.
    launch(16'h0001, 16'h0002, 1'b0);
    finish_op(16'h0001, 16'h0002, 1'b0, 1'b0, "0001_0002");
    launch(16'h0000, 16'h0000, 1'b0);
    finish_op(16'h0000, 16'h0000, 1'b0, 1'b0, "b2b_zero");
    @(negedge clk);
    check("b2b done single cycle", done, 1'b0);

    // start held and operands scrambled during the compare.
    launch(16'h5A5A, 16'h5A3C, 1'b0);
    finish_op(16'h5A5A, 16'h5A3C, 1'b0, 1'b1, "hold");
    begin
      int extra_done;
      extra_done = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      check("hold single done", extra_done, 0);
      check("hold idle after", busy, 1'b0);
    end

    // Asynchronous reset in the middle of a compare.
    launch(16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset outputs", {busy, done, AeqB, AgtB, AltB}, 5'b0);
    begin
      int late_done;
      late_done = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) late_done++;
      end
      check("mid reset no done", late_done, 0);
    end
    rst_n    = 1'b1;
    prev_res = 3'b000;
    @(negedge clk);
    launch(16'h8000, 16'h7FFF, 1'b1);
    finish_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, "post_reset_8000");
    @(negedge clk);

    // Randomised sweep; operands often share upper digits so every latency
    // is exercised, and each pair is compared in both modes.
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 4))
        0:       mask = '0;
        1:       mask = WIDTH'($urandom_range(1, 15));
        2:       mask = WIDTH'($urandom_range(1, 255));
        3:       mask = WIDTH'($urandom_range(1, 4095));
        default: mask = WIDTH'($urandom);
      endcase
      rb = ra ^ mask;
      for (int m = 0; m < 2; m++) begin
        launch(ra, rb, 1'(m));
        finish_op(ra, rb, 1'(m), 1'b0, "sweep");
        // Alternate between idle gaps and back-to-back starts.
        if ($urandom_range(0, 1) == 0) @(negedge clk);
      end
    end
    @(negedge clk);
    check("final done low", done, 1'b0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
